// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 10-key numeric keypad encoder.
package keypad_pkg;

  localparam int NUM_KEYS = 10;
  localparam int DIGIT_W  = 4;

  typedef logic [DIGIT_W-1:0]  digit_t;
  typedef logic [NUM_KEYS-1:0] keyvec_t;

  function automatic logic is_onehot(keyvec_t v);
    return (v != '0) && ((v & (v - keyvec_t'(1))) == '0);
  endfunction

  function automatic digit_t onehot_to_bcd(keyvec_t v);
    digit_t r;
    r = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) r = digit_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/key_sync_debounce.sv
// Synchronizes the raw key lines into clk; optional debounce when ENCODER_DEBOUNCE_EN is defined.
module key_sync_debounce
  import keypad_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] kv,
  output logic                kv_valid
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("key_sync_debounce: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  keyvec_t                sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] fill_q;
  keyvec_t                ks;
  logic                   ks_valid;

  // NOTE: the synchronizer array is a handful of flops, not a RAM, so it is
  // reset along with everything else; fill_q marks when ks holds real samples.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      fill_q <= '0;
    end else begin
      sync_q[0] <= key;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign ks       = sync_q[SYNC_STAGES-1];
  assign ks_valid = fill_q[SYNC_STAGES-1];

`ifdef ENCODER_DEBOUNCE_EN
  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  keyvec_t          last_q, stable_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_vld_q;

  // cnt counts consecutive equal samples including the current one.
  always_comb begin
    cnt_d = CNT_W'(1);
    if (ks == last_q && cnt_q != '0) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_q       <= '0;
      stable_q     <= '0;
      cnt_q        <= '0;
      stable_vld_q <= 1'b0;
    end else if (ks_valid) begin
      last_q <= ks;
      cnt_q  <= cnt_d;
      if (cnt_d == CNT_MAX) begin
        stable_q     <= ks;
        stable_vld_q <= 1'b1;
      end
    end
  end

  assign kv       = stable_q;
  assign kv_valid = stable_vld_q;
`else
  assign kv       = ks;
  assign kv_valid = ks_valid;
`endif

endmodule

// File: rtl/keypad_encoder.sv
// Keypad-to-BCD encoder with single-cycle active-low load strobe per press.
// Optional debounce stage enabled by defining ENCODER_DEBOUNCE_EN.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [9:0] key,
  input  logic       enablen,
  output logic [3:0] d,
  output logic       loadn,
  output logic       pressed,
  output logic       multi
);

  keyvec_t kv;
  logic    kv_valid;
  logic    armed_q;

  key_sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync (
    .clk     (clk),
    .resetn  (resetn),
    .key     (key),
    .kv      (kv),
    .kv_valid(kv_valid)
  );

  // Arming only happens on a genuinely sampled all-released vector, so a key
  // held through reset release stays silent until it is let go.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      d       <= '0;
      loadn   <= 1'b1;
      pressed <= 1'b0;
      multi   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      // NOTE: non-blocking default; the accept branch below overrides it, so
      // the strobe lasts exactly one cycle without a separate clear path.
      loadn   <= 1'b1;
      pressed <= |kv;
      multi   <= (kv != '0) && !is_onehot(kv);
      if (kv == '0) begin
        if (kv_valid) armed_q <= 1'b1;
      end else begin
        if (!enablen && armed_q && is_onehot(kv)) begin
          d     <= onehot_to_bcd(kv);
          loadn <= 1'b0;
        end
        armed_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench for keypad_encoder: directed plan plus randomized presses vs a cycle model.
module tb_keypad_encoder;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [9:0] key = '0;
  logic       enablen = 1'b1;
  logic [3:0] d;
  logic       loadn, pressed, multi;

  always #5 clk = ~clk;

  keypad_encoder dut (
    .clk    (clk),
    .resetn (resetn),
    .key    (key),
    .enablen(enablen),
    .d      (d),
    .loadn  (loadn),
    .pressed(pressed),
    .multi  (multi)
  );

  int tests = 0;
  int failed = 0;
  int strobes = 0;

  // Reference model: key sampled at edge n is seen by the encoder at edge n+2.
  logic [9:0] hist[$];
  logic       m_armed, m_loadn, m_pressed, m_multi;
  logic [3:0] m_d;

  function automatic void model_reset();
    hist.delete();
    m_armed   = 1'b0;
    m_d       = 4'd0;
    m_loadn   = 1'b1;
    m_pressed = 1'b0;
    m_multi   = 1'b0;
  endfunction

  function automatic void model_edge(logic [9:0] k, logic en_n);
    logic [9:0] vis;
    logic       valid;
    hist.push_back(k);
    if (hist.size() > 3) void'(hist.pop_front());
    valid = (hist.size() == 3);
    vis   = valid ? hist[0] : 10'd0;
    m_loadn   = 1'b1;
    m_pressed = (vis != 0);
    m_multi   = ($countones(vis) > 1);
    if (vis == 0) begin
      if (valid) m_armed = 1'b1;
    end else begin
      if (!en_n && m_armed && $countones(vis) == 1) begin
        for (int i = 0; i < 10; i++) if (vis[i]) m_d = 4'(i);
        m_loadn = 1'b0;
      end
      m_armed = 1'b0;
    end
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(key, enablen);
    #1;
    check("loadn", 32'(loadn), 32'(m_loadn));
    check("d", 32'(d), 32'(m_d));
    check("pressed", 32'(pressed), 32'(m_pressed));
    check("multi", 32'(multi), 32'(m_multi));
    if (loadn === 1'b0) strobes++;
  endtask

  task automatic hold(logic [9:0] k, logic en_n, int n);
    key     = k;
    enablen = en_n;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [9:0] k;
    int         r;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_d", 32'(d), 32'd0);
    check("rst_loadn", 32'(loadn), 32'd1);
    check("rst_pressed", 32'(pressed), 32'd0);
    check("rst_multi", 32'(multi), 32'd0);
    resetn = 1'b1;
    strobes = 0;
    hold(10'd0, 1'b1, 10);
    check("idle_no_strobe", 32'(strobes), 32'd0);

    // Key 5: one strobe, third edge after the key changes, none while held.
    hold(10'd0, 1'b0, 2);
    strobes = 0;
    key = 10'b0000100000;
    enablen = 1'b0;
    tick();
    tick();
    check("k5_not_yet", 32'(strobes), 32'd0);
    tick();
    check("k5_latency", 32'(loadn), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check("k5_strobes", 32'(strobes), 32'd1);
    check("k5_d", 32'(d), 32'd5);
    check("k5_pressed", 32'(pressed), 32'd1);

    // Digit range ends: 9 then 0.
    hold(10'd0, 1'b0, 3);
    strobes = 0;
    hold(10'b1000000000, 1'b0, 4);
    check("k9_strobes", 32'(strobes), 32'd1);
    check("k9_d", 32'(d), 32'd9);
    hold(10'd0, 1'b0, 3);
    hold(10'b0000000001, 1'b0, 4);
    check("k0_d", 32'(d), 32'd0);
    check("k0_strobes", 32'(strobes), 32'd2);

    // Two keys together: no load, multi set, then a clean key 3.
    hold(10'd0, 1'b0, 3);
    strobes = 0;
    hold(10'b0000000011, 1'b0, 5);
    check("multi_flag", 32'(multi), 32'd1);
    check("multi_d_hold", 32'(d), 32'd0);
    check("multi_no_strobe", 32'(strobes), 32'd0);
    hold(10'd0, 1'b0, 3);
    hold(10'b0000001000, 1'b0, 4);
    check("k3_d", 32'(d), 32'd3);
    check("k3_strobes", 32'(strobes), 32'd1);

    // Locked out, then enabled while still held: silent until re-pressed.
    hold(10'd0, 1'b1, 3);
    strobes = 0;
    hold(10'b0010000000, 1'b1, 5);
    hold(10'b0010000000, 1'b0, 5);
    check("lock_no_strobe", 32'(strobes), 32'd0);
    check("lock_d_hold", 32'(d), 32'd3);
    hold(10'd0, 1'b0, 3);
    hold(10'b0010000000, 1'b0, 4);
    check("k7_strobes", 32'(strobes), 32'd1);
    check("k7_d", 32'(d), 32'd7);

    // Asynchronous reset during a hold of key 4.
    hold(10'd0, 1'b0, 3);
    hold(10'b0000010000, 1'b0, 4);
    check("k4_d", 32'(d), 32'd4);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    model_reset();
    check("async_d", 32'(d), 32'd0);
    check("async_loadn", 32'(loadn), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    strobes = 0;
    hold(10'b0000010000, 1'b0, 8);
    check("held_thru_reset", 32'(strobes), 32'd0);
    hold(10'd0, 1'b0, 3);
    hold(10'b0000010000, 1'b0, 4);
    check("k4_again_strobes", 32'(strobes), 32'd1);
    check("k4_again_d", 32'(d), 32'd4);

    // Randomized presses, chords, gaps and lockouts against the model.
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 65)      k = 10'd1 << $urandom_range(0, 9);
      else if (r < 80) k = (10'd1 << $urandom_range(0, 9)) | (10'd1 << $urandom_range(0, 9));
      else             k = 10'd0;
      hold(k, ($urandom_range(0, 4) == 0), int'($urandom_range(1, 6)));
      hold(10'd0, ($urandom_range(0, 4) == 0), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
